spi_accel_responder: RTL and testbench
======================================

// Module: spi_accel_responder
// PURPOSE
//  SPI mode-0 responder modelling the accelerometer side of our SPI link: decodes
//  0x0A write-register / 0x0B read-register transactions into a byte register map.
//  Serves as sim/FPGA loopback target for the spi master; all SPI pins are oversampled
//  on clk (100 MHz vs 5 MHz sclk); no logic runs on sclk.
// PARAMETERS
//  REG_DEPTH    64  register map size in bytes (address wraps modulo REG_DEPTH; power of 2)
//  SYNC_STAGES  2   flops per synchroniser on sclk/cs/mosi (>=2)
// PORTS
//  clk         in   1  system clock, 100 MHz; single clock domain
//  rst         in   1  asynchronous, active-high reset
//  sclk        in   1  SPI serial clock from master (async to clk)
//  cs          in   1  chip select, active low (async)
//  mosi        in   1  master-out data (async)
//  sample_x/y/z in  8  live axis data, readable at 0x08/0x09/0x0A
//  miso        out  1  slave-out data, 0 when miso_oe=0
//  miso_oe     out  1  1 while a read data phase is active
//  measure_en  out  1  POWER_CTL(0x2D)[1:0]==2'b10
//  soft_rst    out  1  one-clk pulse on soft-reset command
// BEHAVIOUR
//  Reset: FSM=IDLE, shift regs 0, all RW regs 0x00, miso=0, miso_oe=0, measure_en=0, soft_rst=0.
//  Sync: sclk/cs/mosi through SYNC_STAGES flops; rise/fall = registered edge detect on synced sclk.
//  Mode 0: mosi sampled MSB-first on sclk rise; miso updated on sclk fall.
//  FSM (advances only on sclk rise with synced cs=0; bit_cnt 0..7, byte done at bit_cnt==7):
//   IDLE -> CMD on cs fall; bit_cnt=0.
//   CMD  -> ADDR if byte==0x0A or 0x0B (latch cmd); else -> IGNORE.
//   ADDR -> WR (cmd 0x0A) or RD (cmd 0x0B); latch addr.
//   WR: each full byte written to reg[addr] (RW addresses only), addr++ mod REG_DEPTH.
//   RD: shift out reg[addr], addr++ after each byte; incoming mosi ignored.
//   IGNORE: stays until cs rises; miso_oe=0.
//   Any state: synced cs=1 -> IDLE in next clk; partial byte discarded, never written.
//  Read timing: on sclk fall following the 8th rise of ADDR (and of each RD byte),
//   load tx_shift with read value, miso=bit7, miso_oe=1; subsequent falls shift left.
//   miso_oe drops the clk after cs rises. Edge-to-miso latency <= SYNC_STAGES+2 clk.
//  Register map: 0x00=0xAD,0x01=0x1D,0x02=0xF2,0x03=0x01 (RO constants);
//   0x08/09/0A=sample_x/y/z, snapshotted at ADDR-byte completion (coherent multibyte read);
//   0x1F SOFT_RESET reads 0x00; all other addresses RW storage. Writes to RO ignored.
//  Soft reset: write 0x52 to 0x1F -> next clk soft_rst=1 for one clk, all RW regs 0x00,
//   measure_en=0; transaction continues (further bytes still written at addr 0x20+).
//   Write other than 0x52 to 0x1F: no effect.
//  Wrap: addr REG_DEPTH-1 increments to 0x00 within one burst, both directions.
//  Simultaneous cs rise and sclk rise in same clk: cs wins, byte discarded.
//  rst mid-transaction: immediate IDLE, map cleared; next cs fall required to restart.
// STRUCTURE
//  spi_pkg: CMD_WRITE=8'h0A, CMD_READ=8'h0B, SOFT_RST_KEY=8'h52, register address
//   constants (DEVID_AD, PARTID, XDATA..ZDATA, SOFT_RESET=8'h1F, POWER_CTL=8'h2D),
//   typedef enum logic [2:0] {IDLE,CMD,ADDR,WR,RD,IGNORE} spi_resp_state_t.
//  Sub-module spi_pin_sync: SYNC_STAGES synchroniser + rise/fall strobes for sclk,
//   synced cs/mosi; instantiated once. Top holds FSM, shift regs, register map.
// TESTING (bench drives 5 MHz mode-0 master on clk=100 MHz)
//  1 Write 0A 2D 02, then read 0B 2D 00 -> measure_en=1 after byte 3; read byte=0x02.
//  2 Read 0B 00 00 00 00 00 -> miso bytes AD 1D F2 01; miso_oe=1 only in data bytes.
//  3 sample_x=0x11,y=0x22,z=0x33; read 0B 08 xx xx xx, change sample_y mid-burst -> 11 22 33.
//  4 Write 0A 3F 5A 6B -> reg[0x3F]=0x5A, reg[0x00] unchanged (RO), burst wraps; read 0B 3F -> 5A.
//  5 Write 0A 2D 02 then 0A 1F 52 -> soft_rst 1-clk pulse, measure_en=0, reg[0x2D] reads 0x00.
//  6 Send 0A 20 + 4 bits then cs high; also cmd 0x55 -> reg[0x20] unchanged, miso_oe=0, IDLE.

Source files
------------

// File: rtl/spi_accel_responder_pkg.sv
// Shared constants for the SPI accelerometer responder.
// Contents: command bytes, soft-reset key, register addresses, read-only
// identification values, FSM state type, and the helper is_rw_addr().
package spi_accel_responder_pkg;

    localparam logic [7:0] CMD_WRITE    = 8'h0A;
    localparam logic [7:0] CMD_READ     = 8'h0B;
    localparam logic [7:0] SOFT_RST_KEY = 8'h52;

    localparam logic [7:0] DEVID_AD   = 8'h00;
    localparam logic [7:0] DEVID_MST  = 8'h01;
    localparam logic [7:0] PARTID     = 8'h02;
    localparam logic [7:0] REVID      = 8'h03;
    localparam logic [7:0] XDATA      = 8'h08;
    localparam logic [7:0] YDATA      = 8'h09;
    localparam logic [7:0] ZDATA      = 8'h0A;
    localparam logic [7:0] SOFT_RESET = 8'h1F;
    localparam logic [7:0] POWER_CTL  = 8'h2D;

    localparam logic [7:0] DEVID_AD_VAL  = 8'hAD;
    localparam logic [7:0] DEVID_MST_VAL = 8'h1D;
    localparam logic [7:0] PARTID_VAL    = 8'hF2;
    localparam logic [7:0] REVID_VAL     = 8'h01;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, WR, RD, IGNORE} spi_resp_state_t;

    // True for plain storage locations. ID constants, live axis data and the
    // soft-reset command location are not backed by storage.
    function automatic logic is_rw_addr(input logic [7:0] a);
        return !(a inside {DEVID_AD, DEVID_MST, PARTID, REVID,
                           XDATA, YDATA, ZDATA, SOFT_RESET});
    endfunction

endpackage

// File: rtl/spi_accel_responder_if.sv
// SPI pin bundle between a master and the accelerometer responder.
// Signals: sclk, cs (active low), mosi driven by the master;
// miso and miso_oe driven by the responder.
interface spi_accel_responder_if;
    logic sclk;
    logic cs;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output sclk, output cs, output mosi, input miso, input miso_oe);
    modport slave  (input sclk, input cs, input mosi, output miso, output miso_oe);
endinterface

// File: rtl/spi_accel_responder_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain.
// Ports: clk, rst (async, active high); i_sclk/i_cs/i_mosi raw pins;
// o_sclk_rise/o_sclk_fall one-clk strobes; o_cs/o_mosi synchronised levels;
// o_cs_fall one-clk strobe on chip-select assertion.
module spi_accel_responder_pin_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sclk,
    input  logic i_cs,
    input  logic i_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs,
    output logic o_cs_fall,
    output logic o_mosi
);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;
    logic                   r_cs_prev;

    // cs chain resets low: if cs is already asserted when reset releases,
    // no fall is seen and the master must deassert/reassert to start again.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sclk_prev <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_prev   <= r_cs_sync[SYNC_STAGES-1];
        end
    end

    assign o_sclk_rise = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
    assign o_sclk_fall = ~r_sclk_sync[SYNC_STAGES-1] & r_sclk_prev;
    assign o_cs        = r_cs_sync[SYNC_STAGES-1];
    assign o_cs_fall   = ~r_cs_sync[SYNC_STAGES-1] & r_cs_prev;
    assign o_mosi      = r_mosi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_accel_responder.sv
// SPI mode-0 responder emulating the accelerometer end of the link.
// Decodes 0x0A write / 0x0B read bursts into a byte register map.
// Ports: clk, rst (async, active high); spi (slave modport: sclk, cs, mosi
// in; miso, miso_oe out); sample_x/y/z live axis data; measure_en from
// POWER_CTL[1:0]==2'b10; soft_rst one-clk pulse on soft-reset command.
//
// state  | meaning
// IDLE   | cs deasserted or waiting for a fresh cs fall
// CMD    | shifting in command byte
// ADDR   | shifting in start address
// WR     | each complete byte written at addr, addr increments
// RD     | map shifted out on miso, addr increments per byte
// IGNORE | unknown command, wait for cs deassert
module spi_accel_responder
    import spi_accel_responder_pkg::*;
#(
    parameter int REG_DEPTH   = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    spi_accel_responder_if.slave         spi,
    input  logic [7:0]                   sample_x,
    input  logic [7:0]                   sample_y,
    input  logic [7:0]                   sample_z,
    output logic                         measure_en,
    output logic                         soft_rst
);

    localparam int AW = $clog2(REG_DEPTH);
    localparam logic [AW-1:0] PWR_IDX = AW'(POWER_CTL);

    logic w_sclk_rise, w_sclk_fall, w_cs_s, w_cs_fall, w_mosi_s;

    spi_accel_responder_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_pin_sync (
        .clk         (clk),
        .rst         (rst),
        .i_sclk      (spi.sclk),
        .i_cs        (spi.cs),
        .i_mosi      (spi.mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_cs        (w_cs_s),
        .o_cs_fall   (w_cs_fall),
        .o_mosi      (w_mosi_s)
    );

    spi_resp_state_t r_state, w_state_nxt;
    logic [2:0]      r_bit_cnt;
    logic [6:0]      r_rx_shift;
    logic [7:0]      r_tx_shift;
    logic            r_tx_active;
    logic            r_cmd_rd;
    logic [AW-1:0]   r_addr;
    logic [7:0]      r_snap_x, r_snap_y, r_snap_z;
    logic [7:0]      r_regs [REG_DEPTH];
    logic            r_soft_rst;
    logic [7:0]      w_byte;
    logic            w_byte_done;
    logic [7:0]      w_rd_val;
    logic            w_miso, w_miso_oe;

    // cs wins over a coincident sclk rise, so a truncated byte never lands.
    assign w_byte      = {r_rx_shift, w_mosi_s};
    assign w_byte_done = w_sclk_rise && !w_cs_s && (r_bit_cnt == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_s) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE:    if (w_cs_fall) w_state_nxt = CMD;
                CMD:     if (w_byte_done)
                             w_state_nxt = (w_byte == CMD_WRITE || w_byte == CMD_READ) ? ADDR : IGNORE;
                ADDR:    if (w_byte_done) w_state_nxt = r_cmd_rd ? RD : WR;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_miso_oe = 1'b0;
        if (r_state == RD && r_tx_active) w_miso_oe = 1'b1;
        w_miso = w_miso_oe & r_tx_shift[7];
    end

    always_comb begin
        w_rd_val = r_regs[r_addr];
        case (8'(r_addr))
            DEVID_AD:   w_rd_val = DEVID_AD_VAL;
            DEVID_MST:  w_rd_val = DEVID_MST_VAL;
            PARTID:     w_rd_val = PARTID_VAL;
            REVID:      w_rd_val = REVID_VAL;
            XDATA:      w_rd_val = r_snap_x;
            YDATA:      w_rd_val = r_snap_y;
            ZDATA:      w_rd_val = r_snap_z;
            SOFT_RESET: w_rd_val = 8'h00;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bit_cnt   <= '0;
            r_rx_shift  <= '0;
            r_tx_shift  <= '0;
            r_tx_active <= 1'b0;
            r_cmd_rd    <= 1'b0;
            r_addr      <= '0;
            r_snap_x    <= '0;
            r_snap_y    <= '0;
            r_snap_z    <= '0;
            r_soft_rst  <= 1'b0;
            for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
        end else begin
            r_soft_rst <= 1'b0;
            if (w_cs_s || r_state == IDLE) begin
                r_bit_cnt   <= '0;
                r_rx_shift  <= '0;
                r_tx_active <= 1'b0;
            end else begin
                if (w_sclk_rise) begin
                    r_rx_shift <= w_byte[6:0];
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                end
                if (w_byte_done) begin
                    case (r_state)
                        CMD: r_cmd_rd <= (w_byte == CMD_READ);
                        ADDR: begin
                            r_addr   <= w_byte[AW-1:0];
                            // Snapshot so a multibyte axis read is coherent.
                            r_snap_x <= sample_x;
                            r_snap_y <= sample_y;
                            r_snap_z <= sample_z;
                        end
                        WR: begin
                            if (is_rw_addr(8'(r_addr))) r_regs[r_addr] <= w_byte;
                            if (8'(r_addr) == SOFT_RESET && w_byte == SOFT_RST_KEY) begin
                                r_soft_rst <= 1'b1;
                                for (int i = 0; i < REG_DEPTH; i++) r_regs[i] <= '0;
                            end
                            r_addr <= r_addr + AW'(1);
                        end
                        RD: r_addr <= r_addr + AW'(1);
                        default: ;
                    endcase
                end
                // bit_cnt==0 on a fall in RD means a byte boundary just passed:
                // present the next byte; otherwise keep shifting.
                if (w_sclk_fall && r_state == RD) begin
                    if (r_bit_cnt == 3'd0) begin
                        r_tx_shift  <= w_rd_val;
                        r_tx_active <= 1'b1;
                    end else begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b0};
                    end
                end
            end
        end
    end

    assign spi.miso    = w_miso;
    assign spi.miso_oe = w_miso_oe;
    assign measure_en  = (r_regs[PWR_IDX][1:0] == 2'b10);
    assign soft_rst    = r_soft_rst;

endmodule

// File: tb/tb_spi_accel_responder.sv
module tb_spi_accel_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sample_x = 8'h00, sample_y = 8'h00, sample_z = 8'h00;
    logic       measure_en, soft_rst;

    spi_accel_responder_if spi_if ();

    spi_accel_responder #(.REG_DEPTH(64), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .spi        (spi_if),
        .sample_x   (sample_x),
        .sample_y   (sample_y),
        .sample_z   (sample_z),
        .measure_en (measure_en),
        .soft_rst   (soft_rst)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    bit [7:0] mregs [64];
    bit [7:0] tx_q[$], rx_q[$], exp_q[$];
    bit       oemin_q[$], oemax_q[$];
    int       sr_cycles = 0, sr_pulses = 0;
    bit       sr_prev = 1'b0;

    always @(negedge clk) begin
        if (soft_rst) sr_cycles++;
        if (soft_rst && !sr_prev) sr_pulses++;
        sr_prev = soft_rst;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time budget expired");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

    // ---------------- reference model (byte-level transaction semantics) ----
    function automatic bit model_rw(int a);
        return !(a <= 3 || (a >= 8 && a <= 10) || a == 31);
    endfunction

    function automatic bit [7:0] model_val(int a, bit [7:0] sx, bit [7:0] sy, bit [7:0] sz);
        case (a)
            0: return 8'hAD;
            1: return 8'h1D;
            2: return 8'hF2;
            3: return 8'h01;
            8: return sx;
            9: return sy;
            10: return sz;
            31: return 8'h00;
            default: return mregs[a];
        endcase
    endfunction

    // Applies the first nbytes complete bytes of tx_q; fills exp_q with the
    // bytes a read burst should return. Samples are taken at call time.
    function automatic void model_txn(int nbytes);
        int a;
        bit [7:0] sx = sample_x, sy = sample_y, sz = sample_z;
        exp_q.delete();
        if (nbytes < 2) return;
        if (tx_q[0] != 8'h0A && tx_q[0] != 8'h0B) return;
        a = int'(tx_q[1]) % 64;
        for (int i = 2; i < nbytes; i++) begin
            if (tx_q[0] == 8'h0B) begin
                exp_q.push_back(model_val(a, sx, sy, sz));
            end else begin
                if (model_rw(a)) mregs[a] = tx_q[i];
                if (a == 31 && tx_q[i] == 8'h52)
                    for (int j = 0; j < 64; j++) mregs[j] = 8'h00;
            end
            a = (a + 1) % 64;
        end
    endfunction

    function automatic bit model_meas();
        return mregs[45][1:0] == 2'b10;
    endfunction

    // ---------------- mode-0 master, 5 MHz sclk ------------------------------
    task automatic spi_xfer(input int nbits, input bit cs_with_last);
        bit [7:0] b, cur;
        bit omin, omax;
        rx_q.delete(); oemin_q.delete(); oemax_q.delete();
        cur = 8'h00; omin = 1'b1; omax = 1'b0;
        spi_if.cs = 1'b0;
        #100;
        for (int k = 0; k < nbits; k++) begin
            b = tx_q[k / 8];
            spi_if.mosi = b[7 - (k % 8)];
            #100;
            spi_if.sclk = 1'b1;
            if (cs_with_last && k == nbits - 1) spi_if.cs = 1'b1;
            #1;
            cur  = {cur[6:0], spi_if.miso};
            omin = omin & spi_if.miso_oe;
            omax = omax | spi_if.miso_oe;
            if (k % 8 == 7) begin
                rx_q.push_back(cur); oemin_q.push_back(omin); oemax_q.push_back(omax);
                omin = 1'b1; omax = 1'b0;
            end
            #99 spi_if.sclk = 1'b0;
        end
        #100 spi_if.cs = 1'b1;
        #400;
    endtask

    // ---------------- tests ---------------------------------------------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (spi_if.miso !== 1'b0) begin n_fail++; $display("FAIL reset_miso got %b exp 0", spi_if.miso); end
        n_cmp++; if (spi_if.miso_oe !== 1'b0) begin n_fail++; $display("FAIL reset_miso_oe got %b exp 0", spi_if.miso_oe); end
        n_cmp++; if (measure_en !== 1'b0) begin n_fail++; $display("FAIL reset_measure_en got %b exp 0", measure_en); end
        n_cmp++; if (soft_rst !== 1'b0) begin n_fail++; $display("FAIL reset_soft_rst got %b exp 0", soft_rst); end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_measure();
        tx_q = '{8'h0A, 8'h2D, 8'h02};
        model_txn(3); spi_xfer(24, 1'b0);
        n_cmp++; if (measure_en !== model_meas()) begin n_fail++; $display("FAIL measure_en_set got %b exp %b", measure_en, model_meas()); end
        n_cmp++; if (oemax_q[2] !== 1'b0) begin n_fail++; $display("FAIL measure_wr_oe got %b exp 0", oemax_q[2]); end
        tx_q = '{8'h0B, 8'h2D, 8'h00};
        model_txn(3); spi_xfer(24, 1'b0);
        n_cmp++; if (rx_q[2] !== exp_q[0]) begin n_fail++; $display("FAIL measure_readback got %h exp %h", rx_q[2], exp_q[0]); end
        n_cmp++; if (oemax_q[1] !== 1'b0) begin n_fail++; $display("FAIL measure_addr_oe got %b exp 0", oemax_q[1]); end
    endtask

    task automatic test_const_read();
        tx_q = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        model_txn(6); spi_xfer(48, 1'b0);
        for (int i = 0; i < 6; i++) begin
            if (i >= 2) begin
                n_cmp++; if (rx_q[i] !== exp_q[i-2]) begin n_fail++; $display("FAIL const_read[%0d] got %h exp %h", i, rx_q[i], exp_q[i-2]); end
                n_cmp++; if (oemin_q[i] !== 1'b1) begin n_fail++; $display("FAIL const_oe_data[%0d] got %b exp 1", i, oemin_q[i]); end
            end else begin
                n_cmp++; if (oemax_q[i] !== 1'b0) begin n_fail++; $display("FAIL const_oe_hdr[%0d] got %b exp 0", i, oemax_q[i]); end
            end
        end
    endtask

    task automatic test_snapshot();
        sample_x = 8'h11; sample_y = 8'h22; sample_z = 8'h33;
        tx_q = '{8'h0B, 8'h08, 8'h00, 8'h00, 8'h00};
        model_txn(5);
        fork
            spi_xfer(40, 1'b0);
            begin #4100 sample_y = 8'($urandom_range(0, 255)) ^ 8'h80; end
        join
        for (int i = 2; i < 5; i++) begin
            n_cmp++; if (rx_q[i] !== exp_q[i-2]) begin n_fail++; $display("FAIL snapshot[%0d] got %h exp %h", i, rx_q[i], exp_q[i-2]); end
        end
    endtask

    task automatic test_wrap();
        bit [7:0] r1 = 8'($urandom), r2 = 8'($urandom);
        tx_q = '{8'h0A, 8'h3F, r1, r2};
        model_txn(4); spi_xfer(32, 1'b0);
        tx_q = '{8'h0B, 8'h3F, 8'h00, 8'h00};
        model_txn(4); spi_xfer(32, 1'b0);
        n_cmp++; if (rx_q[2] !== exp_q[0]) begin n_fail++; $display("FAIL wrap_3f got %h exp %h", rx_q[2], exp_q[0]); end
        n_cmp++; if (rx_q[3] !== exp_q[1]) begin n_fail++; $display("FAIL wrap_00 got %h exp %h", rx_q[3], exp_q[1]); end
    endtask

    task automatic test_soft_reset();
        bit [7:0] r = 8'($urandom_range(1, 255));
        tx_q = '{8'h0A, 8'h2D, 8'h02};
        model_txn(3); spi_xfer(24, 1'b0);
        n_cmp++; if (measure_en !== model_meas()) begin n_fail++; $display("FAIL sr_pre_measure got %b exp %b", measure_en, model_meas()); end
        sr_cycles = 0; sr_pulses = 0;
        tx_q = '{8'h0A, 8'h1F, 8'h52, r};
        model_txn(4); spi_xfer(32, 1'b0);
        n_cmp++; if (sr_pulses !== 1) begin n_fail++; $display("FAIL sr_pulses got %0d exp 1", sr_pulses); end
        n_cmp++; if (sr_cycles !== 1) begin n_fail++; $display("FAIL sr_width got %0d exp 1", sr_cycles); end
        n_cmp++; if (measure_en !== model_meas()) begin n_fail++; $display("FAIL sr_measure got %b exp %b", measure_en, model_meas()); end
        tx_q = '{8'h0B, 8'h2D, 8'h00};
        model_txn(3); spi_xfer(24, 1'b0);
        n_cmp++; if (rx_q[2] !== exp_q[0]) begin n_fail++; $display("FAIL sr_2d got %h exp %h", rx_q[2], exp_q[0]); end
        tx_q = '{8'h0B, 8'h1F, 8'h00, 8'h00};
        model_txn(4); spi_xfer(32, 1'b0);
        n_cmp++; if (rx_q[2] !== exp_q[0]) begin n_fail++; $display("FAIL sr_1f got %h exp %h", rx_q[2], exp_q[0]); end
        n_cmp++; if (rx_q[3] !== exp_q[1]) begin n_fail++; $display("FAIL sr_continue_20 got %h exp %h", rx_q[3], exp_q[1]); end
    endtask

    task automatic test_abort();
        tx_q = '{8'h0A, 8'h20, ~mregs[32]};
        model_txn(2); spi_xfer(20, 1'b0);
        tx_q = '{8'h55, 8'($urandom), 8'($urandom)};
        model_txn(3); spi_xfer(24, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (oemax_q[i] !== 1'b0) begin n_fail++; $display("FAIL ignore_oe[%0d] got %b exp 0", i, oemax_q[i]); end
        end
        tx_q = '{8'h0A, 8'h21, ~mregs[33]};
        model_txn(2); spi_xfer(24, 1'b1);
        tx_q = '{8'h0B, 8'h20, 8'h00, 8'h00};
        model_txn(4); spi_xfer(32, 1'b0);
        n_cmp++; if (rx_q[2] !== exp_q[0]) begin n_fail++; $display("FAIL abort_partial_20 got %h exp %h", rx_q[2], exp_q[0]); end
        n_cmp++; if (rx_q[3] !== exp_q[1]) begin n_fail++; $display("FAIL abort_cs_race_21 got %h exp %h", rx_q[3], exp_q[1]); end
    endtask

    task automatic test_random_bursts();
        int len, sel;
        for (int t = 0; t < 12; t++) begin
            sample_x = 8'($urandom); sample_y = 8'($urandom); sample_z = 8'($urandom);
            sel = int'($urandom_range(0, 9));
            tx_q.delete();
            tx_q.push_back(sel < 5 ? 8'h0A : (sel < 9 ? 8'h0B : 8'($urandom)));
            tx_q.push_back(8'($urandom));
            len = int'($urandom_range(1, 4));
            for (int i = 0; i < len; i++) tx_q.push_back(8'($urandom));
            model_txn(tx_q.size());
            spi_xfer(8 * tx_q.size(), 1'b0);
            for (int i = 0; i < rx_q.size(); i++) begin
                if (tx_q[0] == 8'h0B && i >= 2) begin
                    n_cmp++; if (rx_q[i] !== exp_q[i-2]) begin n_fail++; $display("FAIL rand[%0d] byte%0d got %h exp %h", t, i, rx_q[i], exp_q[i-2]); end
                    n_cmp++; if (oemin_q[i] !== 1'b1) begin n_fail++; $display("FAIL rand[%0d] oe%0d got %b exp 1", t, i, oemin_q[i]); end
                end else begin
                    n_cmp++; if (oemax_q[i] !== 1'b0) begin n_fail++; $display("FAIL rand[%0d] oe%0d got %b exp 0", t, i, oemax_q[i]); end
                end
            end
            n_cmp++; if (measure_en !== model_meas()) begin n_fail++; $display("FAIL rand[%0d] measure_en got %b exp %b", t, measure_en, model_meas()); end
        end
    endtask

    initial begin
        spi_if.sclk = 1'b0;
        spi_if.cs   = 1'b1;
        spi_if.mosi = 1'b0;
        test_reset();
        test_measure();
        test_const_read();
        test_snapshot();
        test_wrap();
        test_soft_reset();
        test_abort();
        test_random_bursts();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
